// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_rd_pkg;

    // Output buffer depth. Two entries are enough to cover the RAM's
    // one-cycle read latency at full throughput.
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ram_rd_buf.sv
// Two-entry synchronous FIFO holding read words until the consumer takes them.
module ram_rd_buf
    import ram_rd_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [CNT_W-1:0]  count_q;

    // Storage, pointers and occupancy. The issue logic upstream guarantees
    // that a push never arrives while the buffer is full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the two storage entries are reset as well, because the
            // head word drives the stream data output and must read 0 after reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port block RAM: one write port and one registered read port.
// Each port has its own clock.
module ram_sdp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_write,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clk_read,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // The array has no reset so that it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_write) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port with one cycle of latency. rdata holds between reads.
    always_ff @(posedge clk_read) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous address range on an SDP RAM read port and presents the
// words as a valid/ready stream with a last marker.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [AW-1:0]     base_addr_i,
    input  logic [AW:0]       len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ren_o,
    output logic [AW-1:0]     raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [AW:0]      issue_cnt_q;   // reads still to be issued
    logic [AW:0]      beat_cnt_q;    // beats still to be delivered
    logic [AW-1:0]    addr_q;
    logic             inflight_q;    // a read was issued last cycle
    logic [CNT_W-1:0] buf_count;
    logic             pop;
    logic [2:0]       occupancy;

    assign pop       = m_valid_o & m_ready_i;
    assign m_valid_o = (buf_count != '0);
    assign m_last_o  = m_valid_o && (beat_cnt_q == (AW+1)'(1));
    assign raddr_o   = addr_q;

    // Words that will be held or pending once this cycle's pop completes.
    // A new read is issued only if it still fits in the buffer.
    assign occupancy = 3'(inflight_q) + 3'(buf_count) - 3'(pop);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, status outputs and read issue.
    always_comb begin
        // NOTE: every output of this block gets a default here so that no
        // path through the case statement can leave one unassigned (latch).
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        ren_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                ren_o  = (issue_cnt_q != '0) && (occupancy < 3'd2);
                if (pop && (beat_cnt_q == (AW+1)'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer counters, read address and in-flight flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= ren_o;
            if (state_q == IDLE && start_i) begin
                issue_cnt_q <= len_i;
                beat_cnt_q  <= len_i;
                addr_q      <= base_addr_i;
            end else begin
                if (ren_o) begin
                    issue_cnt_q <= issue_cnt_q - (AW+1)'(1);
                    addr_q      <= addr_q + AW'(1);
                end
                if (pop) begin
                    beat_cnt_q <= beat_cnt_q - (AW+1)'(1);
                end
            end
        end
    end

    // Read data arrives one cycle after ren_o and goes straight into the buffer.
    ram_rd_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (rdata_i),
        .pop       (pop),
        .count     (buf_count),
        .head      (m_data_o)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed self-checking bench for ram_stream_reader attached to ram_sdp.
module tb_ram_stream_reader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int MAX_CYC = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [AW-1:0]     base_addr_i;
    logic [AW:0]       len_i;
    logic              busy_o;
    logic              done_o;
    logic              ren_o;
    logic [AW-1:0]     raddr_o;
    logic [DATA_W-1:0] rdata_i;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic              m_ready_i;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_stream_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ren_o       (ren_o),
        .raddr_o     (raddr_o),
        .rdata_i     (rdata_i),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready_i)
    );

    ram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk_write (clk),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .clk_read  (clk),
        .re        (ren_o),
        .raddr     (raddr_o),
        .rdata     (rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy_o),    32'd0);
        check({tag, "_done"},  32'(done_o),    32'd0);
        check({tag, "_ren"},   32'(ren_o),     32'd0);
        check({tag, "_valid"}, 32'(m_valid_o), 32'd0);
        check({tag, "_last"},  32'(m_last_o),  32'd0);
        check({tag, "_data"},  m_data_o,       32'd0);
        check({tag, "_raddr"}, 32'(raddr_o),   32'd0);
    endtask

    // Runs one transfer. mode 0: ready always high, exact timing checked.
    // mode 1: ready pattern 1,0,0 repeating. inject: pulse start mid-run.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_xfer(input int base, input int len, input int mode, input bit inject);
        int          cyc = 1;
        int          rx = 0;
        int          issued = 0;
        int          first_valid = -1;
        bit          held = 1'b0;
        bit          finished = 1'b0;
        bit          pop;
        logic [31:0] held_data = '0;

        start_i     = 1'b1;
        base_addr_i = AW'(base);
        len_i       = (AW+1)'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        while (!finished) begin
            m_ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            if (inject && cyc == 4) begin
                start_i     = 1'b1;
                base_addr_i = AW'(100);
                len_i       = (AW+1)'(3);
            end else begin
                start_i = 1'b0;
            end
            #1;
            pop = m_valid_o && m_ready_i;
            if (held) begin
                check("hold_valid", 32'(m_valid_o), 32'd1);
                check("hold_data", m_data_o, held_data);
            end
            if (ren_o) begin
                check("raddr", 32'(raddr_o), 32'((base + issued) % DEPTH));
                check("ren_extra", 32'(issued < len), 32'd1);
                check("ren_room", 32'((issued - rx - int'(pop)) < 2), 32'd1);
                issued++;
            end
            if (m_valid_o) begin
                if (first_valid < 0) first_valid = cyc;
                check("last", 32'(m_last_o), 32'(rx == len - 1));
                if (m_ready_i) begin
                    check("data", m_data_o, 32'h1000 + 32'((base + rx) % DEPTH));
                    rx++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = m_data_o;
                end
            end
            if (done_o) begin
                check("done_busy", 32'(busy_o), 32'd0);
                check("done_beats", 32'(rx), 32'(len));
                check("done_issued", 32'(issued), 32'(len));
                if (mode == 0) begin
                    check("first_valid_cyc", 32'(first_valid), 32'd3);
                    check("done_cyc", 32'(cyc), 32'(len + 3));
                end
                finished = 1'b1;
            end else begin
                check("busy", 32'(busy_o), 32'd1);
                if (cyc >= MAX_CYC) begin
                    check("timeout", 32'd0, 32'd1);
                    finished = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        #1;
        check("idle_after", 32'({busy_o, done_o, ren_o, m_valid_o}), 32'd0);
    endtask

    initial begin
        int beats;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        m_ready_i   = 1'b1;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;

        // Preload RAM[i] = 0x1000 + i while the reader is held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            we    = 1'b1;
            waddr = AW'(i);
            wdata = 32'h1000 + 32'(i);
        end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic transfer: base 4, len 8, no back-pressure.
        run_xfer(4, 8, 0, 1'b0);

        // Zero length: straight to DONE, nothing issued or delivered.
        start_i     = 1'b1;
        base_addr_i = AW'(7);
        len_i       = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        #1;
        check("len0_done", 32'(done_o), 32'd1);
        check("len0_busy", 32'(busy_o), 32'd0);
        check("len0_ren", 32'(ren_o), 32'd0);
        check("len0_valid", 32'(m_valid_o), 32'd0);
        @(posedge clk); #2;
        check("len0_done_end", 32'(done_o), 32'd0);
        check("len0_ren_end", 32'(ren_o), 32'd0);
        check("len0_valid_end", 32'(m_valid_o), 32'd0);
        @(posedge clk); #1;

        // Address wrap: 254, 255, 0, 1.
        run_xfer(DEPTH - 2, 4, 0, 1'b0);

        // Back-pressure with ready 1,0,0 repeating.
        run_xfer(30, 6, 1, 1'b0);

        // Start pulse during RUN must be ignored.
        run_xfer(10, 5, 0, 1'b1);

        // Reset mid-transfer after three beats of a len=10 transfer.
        m_ready_i   = 1'b1;
        start_i     = 1'b1;
        base_addr_i = AW'(20);
        len_i       = (AW+1)'(10);
        @(posedge clk); #1;
        start_i = 1'b0;
        beats   = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (m_valid_o) beats++;
            @(posedge clk); #1;
        end
        check("pre_reset_beats", 32'(beats), 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_xfer(40, 5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
